micro_sequencer: RTL

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

---
 rtl/cpu2_pkg.sv | 20 ++
 rtl/micro_sequencer_if.sv | 35 +++
 rtl/prog_mem.sv | 20 ++
 rtl/micro_sequencer.sv | 114 +++++++++++
 4 files changed

// File: rtl/cpu2_pkg.sv
// Shared encodings and default sizes for the micro-sequencer.
package cpu2_pkg;
    localparam int WIDTH_DEF    = 4;
    localparam int CTRLWORD_DEF = 14;
    localparam int PC_W_DEF     = 4;

    typedef enum logic [1:0] {
        OP_EXEC = 2'b00,
        OP_JMP  = 2'b01,
        OP_JZ   = 2'b10,
        OP_HLT  = 2'b11
    } opcode_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_HALT  = 2'b11
    } state_t;
endpackage

// File: rtl/micro_sequencer_if.sv
// Control, program-load and datapath-feedback signals of the micro-sequencer.
// All inputs are sampled on the rising clock edge; there is no ready/valid
// backpressure: ctrl_valid marks the one cycle a control word is live.
interface micro_sequencer_if
    import cpu2_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int CTRLWORD = CTRLWORD_DEF,
    parameter int PC_W     = PC_W_DEF
) ();
    logic                  start;
    logic                  step_mode;
    logic                  step;
    logic                  halt_req;
    logic                  prog_we;
    logic [PC_W-1:0]       prog_addr;
    logic [CTRLWORD+1:0]   prog_data;
    logic [WIDTH-1:0]      alu_result;
    logic [CTRLWORD-1:0]   control;
    logic                  ctrl_valid;
    logic [PC_W-1:0]       pc;
    logic                  busy;
    logic                  done;
    state_t                state_dbg;

    modport master (
        output start, step_mode, step, halt_req, prog_we, prog_addr, prog_data, alu_result,
        input  control, ctrl_valid, pc, busy, done, state_dbg
    );

    modport slave (
        input  start, step_mode, step, halt_req, prog_we, prog_addr, prog_data, alu_result,
        output control, ctrl_valid, pc, busy, done, state_dbg
    );
endinterface

// File: rtl/prog_mem.sv
// Program store: synchronous write, asynchronous read, contents survive reset.
module prog_mem #(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: fetches at pc, issues EXEC control words, handles
// JMP/JZ/HLT, single-step pausing and abort.
module micro_sequencer
    import cpu2_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int CTRLWORD = CTRLWORD_DEF,
    parameter int PC_W     = PC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    micro_sequencer_if.slave bus
);
    state_t              state;
    logic [CTRLWORD-1:0] control_q;
    logic                ctrl_valid_q;
    logic [PC_W-1:0]     pc_q;
    logic                done_q;
    logic                zero_flag;

    logic [CTRLWORD+1:0] word;
    opcode_t             op;
    logic [CTRLWORD-1:0] field;
    logic [PC_W-1:0]     target;
    logic [PC_W-1:0]     pc_inc;
    logic                zero_now;
    logic                issue;
    logic                mem_we;
    state_t              after_issue;

    assign mem_we = bus.prog_we && (state == S_IDLE || state == S_HALT);

    prog_mem #(.DW(CTRLWORD + 2), .AW(PC_W)) u_prog_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (bus.prog_addr),
        .wdata (bus.prog_data),
        .raddr (pc_q),
        .rdata (word)
    );

    assign op     = opcode_t'(word[CTRLWORD+1:CTRLWORD]);
    assign field  = word[CTRLWORD-1:0];
    assign target = field[PC_W-1:0];
    assign pc_inc = pc_q + 1'b1;

    // The flag follows the word currently on control, so a JZ right after
    // an EXEC branches on that EXEC's ALU result rather than a stale one.
    assign zero_now    = ctrl_valid_q ? (bus.alu_result == '0) : zero_flag;
    assign issue       = (state == S_RUN) || (state == S_PAUSE && bus.step);
    assign after_issue = (state == S_RUN && !bus.step_mode) ? S_RUN : S_PAUSE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            control_q    <= '0;
            ctrl_valid_q <= 1'b0;
            pc_q         <= '0;
            done_q       <= 1'b0;
            zero_flag    <= 1'b0;
        end else begin
            zero_flag    <= zero_now;
            control_q    <= '0;
            ctrl_valid_q <= 1'b0;
            case (state)
                S_IDLE, S_HALT: begin
                    if (bus.start) begin
                        pc_q      <= '0;
                        done_q    <= 1'b0;
                        zero_flag <= 1'b0;
                        state     <= S_RUN;
                    end
                end
                S_RUN, S_PAUSE: begin
                    if (bus.halt_req) begin
                        state <= S_IDLE;
                    end else if (issue) begin
                        case (op)
                            OP_EXEC: begin
                                control_q    <= field;
                                ctrl_valid_q <= 1'b1;
                                pc_q         <= pc_inc;
                                state        <= after_issue;
                            end
                            OP_JMP: begin
                                pc_q  <= target;
                                state <= after_issue;
                            end
                            OP_JZ: begin
                                pc_q  <= zero_now ? target : pc_inc;
                                state <= after_issue;
                            end
                            OP_HLT: begin
                                done_q <= 1'b1;
                                state  <= S_HALT;
                            end
                            default: state <= S_IDLE;
                        endcase
                    end else if (!bus.step_mode) begin
                        state <= S_RUN;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.control    = control_q;
    assign bus.ctrl_valid = ctrl_valid_q;
    assign bus.pc         = pc_q;
    assign bus.done       = done_q;
    assign bus.busy       = (state == S_RUN) || (state == S_PAUSE);
    assign bus.state_dbg  = state;
endmodule
